// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one bit per clock.
// Start/Busy/Done handshake; BCD/Overflow are held between conversions.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | waiting for Start; outputs hold the last result
// S_CONV | one double-dabble iteration per clock, BIN_W clocks in total
module bin_to_bcd_seq #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  Clock,
    input  logic                  Resetn,
    input  logic                  Start,
    input  logic [BIN_W-1:0]      Bin,
    output logic                  Busy,
    output logic                  Done,
    output logic [4*DIGITS-1:0]   BCD,
    output logic                  Overflow
);

    localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

    typedef enum logic {S_IDLE, S_CONV} state_t;

    state_t              state;
    logic [BIN_W-1:0]    shreg;
    logic [4*DIGITS-1:0] scratch;
    logic                ovf;
    logic [CNT_W-1:0]    count;

    logic [4*DIGITS-1:0] adj;
    logic [4*DIGITS-1:0] scratch_nxt;
    logic [BIN_W-1:0]    shreg_nxt;
    logic                ovf_nxt;

    // Add-3 is per digit with no carry between digits; the bit leaving the
    // top digit is the only evidence that the value no longer fits.
    always_comb begin
        adj = scratch;
        for (int k = 0; k < DIGITS; k++) begin
            if (scratch[4*k +: 4] >= 4'd5)
                adj[4*k +: 4] = scratch[4*k +: 4] + 4'd3;
        end
        scratch_nxt = {adj[4*DIGITS-2:0], shreg[BIN_W-1]};
        shreg_nxt   = shreg << 1;
        ovf_nxt     = ovf | adj[4*DIGITS-1];
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state    <= S_IDLE;
            shreg    <= '0;
            scratch  <= '0;
            ovf      <= 1'b0;
            count    <= '0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
            BCD      <= '0;
            Overflow <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (Start) begin
                        shreg   <= Bin;
                        scratch <= '0;
                        ovf     <= 1'b0;
                        count   <= CNT_W'(BIN_W - 1);
                        Busy    <= 1'b1;
                        state   <= S_CONV;
                    end
                end
                S_CONV: begin
                    shreg   <= shreg_nxt;
                    scratch <= scratch_nxt;
                    ovf     <= ovf_nxt;
                    if (count == '0) begin
                        BCD      <= scratch_nxt;
                        Overflow <= ovf_nxt;
                        Done     <= 1'b1;
                        Busy     <= 1'b0;
                        state    <= S_IDLE;
                    end else begin
                        count <= count - CNT_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: a 3-digit and a 2-digit instance checked against
// a decimal-arithmetic reference model with directed and random operands.
module tb_bin_to_bcd_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        sel;
    logic [7:0]  bin;

    logic        start3, busy3, done3, ovf3;
    logic [11:0] bcd3;
    logic        start2, busy2, done2, ovf2;
    logic [7:0]  bcd2;

    logic        busy_s, done_s, ovf_s;
    logic [11:0] bcd_s;

    always #5 clk = ~clk;

    assign start3 = start & ~sel;
    assign start2 = start & sel;
    assign busy_s = sel ? busy2 : busy3;
    assign done_s = sel ? done2 : done3;
    assign ovf_s  = sel ? ovf2  : ovf3;
    assign bcd_s  = sel ? {4'h0, bcd2} : bcd3;

    bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) dut3 (
        .Clock(clk), .Resetn(rst_n), .Start(start3), .Bin(bin),
        .Busy(busy3), .Done(done3), .BCD(bcd3), .Overflow(ovf3)
    );

    bin_to_bcd_seq #(.BIN_W(8), .DIGITS(2)) dut2 (
        .Clock(clk), .Resetn(rst_n), .Start(start2), .Bin(bin),
        .Busy(busy2), .Done(done2), .BCD(bcd2), .Overflow(ovf2)
    );

    int          total  = 0;
    int          passed = 0;
    logic [11:0] prev [2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference: decimal digits of the value modulo 10^nd, by plain arithmetic.
    function automatic logic [11:0] ref_bcd(input int v, input int nd);
        int          m;
        logic [11:0] r;
        m = v % ((nd == 2) ? 100 : 1000);
        r = '0;
        for (int k = 0; k < nd; k++) begin
            r[4*k +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return r;
    endfunction

    function automatic logic ref_ovf(input int v, input int nd);
        return v > ((nd == 2) ? 99 : 999);
    endfunction

    // One conversion on the selected instance. With hold set, Start stays high
    // and Bin keeps changing while busy; neither may affect the result.
    task automatic run(input int b, input bit hold);
        int          n;
        int          nd;
        bit          busy_ok;
        logic [11:0] expb;
        nd = sel ? 2 : 3;
        @(negedge clk);
        start = 1'b1;
        bin   = 8'(b);
        @(negedge clk);
        check("busy_after_accept", 32'(busy_s), 32'd1);
        check("bcd_held_at_start", 32'(bcd_s), 32'(prev[sel]));
        start   = hold;
        bin     = 8'($urandom);
        n       = 0;
        busy_ok = 1'b1;
        while (!done_s && n < 20) begin
            @(negedge clk);
            n++;
            start = hold && (n < 7);
            bin   = 8'($urandom);
            if (!done_s && !busy_s) busy_ok = 1'b0;
        end
        expb = ref_bcd(b, nd);
        check("latency", 32'(n), 32'd8);
        check("busy_during_conv", 32'(busy_ok), 32'd1);
        check("busy_at_done", 32'(busy_s), 32'd0);
        check("bcd", 32'(bcd_s), 32'(expb));
        check("overflow", 32'(ovf_s), 32'(ref_ovf(b, nd)));
        prev[sel] = expb;
        @(negedge clk);
        check("done_pulse_drop", 32'(done_s), 32'd0);
        check("bcd_hold_after", 32'(bcd_s), 32'(expb));
    endtask

    initial begin
        int  last;
        int  ndone;
        bit  no_done;

        rst_n   = 1'b0;
        start   = 1'b0;
        sel     = 1'b0;
        bin     = '0;
        prev[0] = '0;
        prev[1] = '0;
        repeat (3) @(negedge clk);
        check("rst_busy3", 32'(busy3), 32'd0);
        check("rst_done3", 32'(done3), 32'd0);
        check("rst_bcd3", 32'(bcd3), 32'd0);
        check("rst_ovf3", 32'(ovf3), 32'd0);
        check("rst_bcd2", 32'(bcd2), 32'd0);
        rst_n = 1'b1;

        run(255, 1'b0);
        check("bcd_255", 32'(bcd3), 32'h255);
        run(0, 1'b0);
        run(99, 1'b0);
        run(100, 1'b0);
        check("bcd_100", 32'(bcd3), 32'h100);
        run(57, 1'b1);
        check("bcd_ignored_start", 32'(bcd3), 32'h057);

        // Reset abandoned mid-conversion: outputs clear at once, no Done follows.
        @(negedge clk);
        start = 1'b1;
        bin   = 8'd200;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy3), 32'd0);
        check("midrst_done", 32'(done3), 32'd0);
        check("midrst_bcd", 32'(bcd3), 32'd0);
        @(negedge clk);
        rst_n   = 1'b1;
        prev[0] = '0;
        prev[1] = '0;
        no_done = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (done3 || busy3) no_done = 1'b0;
        end
        check("midrst_no_done", 32'(no_done), 32'd1);
        run(37, 1'b0);
        check("bcd_37", 32'(bcd3), 32'h037);

        // Start held high: a new conversion every 9 cycles.
        @(negedge clk);
        start = 1'b1;
        bin   = 8'd128;
        last  = -1;
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done3) begin
                if (last >= 0) check("retrigger_period", 32'(i - last), 32'd9);
                check("retrigger_bcd", 32'(bcd3), 32'h128);
                last = i;
                ndone++;
            end
        end
        check("retrigger_count", 32'(ndone), 32'd4);
        start = 1'b0;
        repeat (12) @(negedge clk);
        prev[0] = 12'h128;

        for (int i = 0; i < 20; i++) run(int'($urandom_range(0, 255)), 1'(i % 2));
        for (int v = 0; v < 256; v++) run(v, 1'b0);

        @(negedge clk);
        sel = 1'b1;
        run(200, 1'b0);
        check("d2_bcd_200", 32'(bcd2), 32'h00);
        check("d2_ovf_200", 32'(ovf2), 32'd1);
        run(42, 1'b0);
        check("d2_bcd_42", 32'(bcd2), 32'h42);
        check("d2_ovf_42", 32'(ovf2), 32'd0);
        for (int v = 0; v < 256; v++) run(v, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passed, total);
        $fatal(1);
    end

endmodule
